// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: picks hold/PC+4/redirect, marks IF/ID valid or bubble, emits flush.
// Define FETCH_PERF_EN to build the fetched/stall performance counters; otherwise both ports read 0.
module fetch_ctrl #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter logic [1:0]  PCSEL_HOLD       = 2'b00,
  parameter logic [1:0]  PCSEL_PC4        = 2'b01,
  parameter logic [1:0]  PCSEL_BRANCH     = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            id_stall,
  input  logic            imem_rdy,
  output logic [1:0]      pcsel,
  output logic [XLEN-1:0] br_dest_o,
  output logic            if_valid,
  output logic            flush,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
);

  localparam logic [2:0] ST_BOOT    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_MEMWAIT = 3'd2;
  localparam logic [2:0] ST_STALL   = 3'd3;
  localparam logic [2:0] ST_BUBBLE  = 3'd4;

  localparam logic [1:0] CNT_LOAD = 2'(REDIRECT_BUBBLES);
  localparam logic [2:0] ST_AFTER_REDIRECT = (CNT_LOAD == 2'd0) ? ST_RUN : ST_BUBBLE;

  logic [2:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            if_valid_q, if_valid_d;
  logic            flush_q, flush_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if_valid_d = if_valid_q;
    flush_d    = 1'b0;
    pcsel      = PCSEL_HOLD;
    br_dest_o  = '0;
    if (reset) begin
      state_d    = ST_BOOT;
      cnt_d      = '0;
      pend_d     = 1'b0;
      pend_tgt_d = '0;
      if_valid_d = 1'b0;
    end else if (state_q == ST_BOOT) begin
      state_d    = ST_RUN;
      if_valid_d = 1'b0;
    end else if (br_taken && imem_rdy && state_q != ST_MEMWAIT) begin
      pcsel      = PCSEL_BRANCH;
      br_dest_o  = br_target;
      flush_d    = 1'b1;
      if_valid_d = 1'b0;
      pend_d     = 1'b0;
      cnt_d      = CNT_LOAD;
      state_d    = ST_AFTER_REDIRECT;
    end else if (br_taken) begin
      // Newest branch overwrites the latched target; flush only for the first one.
      pend_d     = 1'b1;
      pend_tgt_d = br_target;
      flush_d    = ~pend_q;
      if_valid_d = 1'b0;
      state_d    = ST_MEMWAIT;
    end else if (!imem_rdy) begin
      state_d    = ST_MEMWAIT;
      if_valid_d = 1'b0;
    end else if (pend_q) begin
      pcsel      = PCSEL_BRANCH;
      br_dest_o  = pend_tgt_q;
      pend_d     = 1'b0;
      if_valid_d = 1'b0;
      cnt_d      = CNT_LOAD;
      state_d    = ST_AFTER_REDIRECT;
    end else if (cnt_q != 2'd0) begin
      // Bubble drain; a wait state interrupting it resumes here with the count kept.
      pcsel      = PCSEL_PC4;
      if_valid_d = 1'b0;
      cnt_d      = cnt_q - 2'd1;
      state_d    = (cnt_q == 2'd1) ? ST_RUN : ST_BUBBLE;
    end else if (id_stall) begin
      state_d    = ST_STALL;
    end else begin
      pcsel      = PCSEL_PC4;
      if_valid_d = 1'b1;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      if_valid_q <= if_valid_d;
      flush_q    <= flush_d;
    end
  end

  assign if_valid = if_valid_q;
  assign flush    = flush_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (if_valid_q && !id_stall) fetched_q <= fetched_q + 32'd1;
      if (state_q != ST_BOOT && pcsel == PCSEL_HOLD) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, decode stall, redirect, wait-state branch, reset discard, perf.
module tb_fetch_ctrl;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        id_stall = 1'b0;
  logic        imem_rdy = 1'b1;
  logic [1:0]  pcsel;
  logic [31:0] br_dest_o;
  logic        if_valid;
  logic        flush;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_ctrl #(.XLEN(32), .REDIRECT_BUBBLES(1)) dut (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .id_stall(id_stall), .imem_rdy(imem_rdy), .pcsel(pcsel), .br_dest_o(br_dest_o),
    .if_valid(if_valid), .flush(flush), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then let combinational outputs settle.
  task automatic cyc(input logic rst, input logic br, input logic [31:0] tgt,
                     input logic stall, input logic rdy);
    @(negedge clk);
    reset = rst; br_taken = br; br_target = tgt; id_stall = stall; imem_rdy = rdy;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("rst_pcsel", 32'(pcsel), 32'd0);
    check("rst_dest", br_dest_o, 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pstall", perf_stall, 32'd0);
    check("rst_pfetch", perf_fetched, 32'd0);

    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("boot_pcsel", 32'(pcsel), 32'd0);
    check("boot_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("run1_pcsel", 32'(pcsel), 32'd1);
    check("run1_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("run_pcsel", 32'(pcsel), 32'd1);
      check("run_valid", 32'(if_valid), 32'd1);
    end

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check("stall_pcsel", 32'(pcsel), 32'd0);
      check("stall_valid", 32'(if_valid), 32'd1);
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("unstall_pcsel", 32'(pcsel), 32'd1);
    check("unstall_valid", 32'(if_valid), 32'd1);
    check("perf_fetch9", perf_fetched, PERF ? 32'd9 : 32'd0);
    check("perf_stall3", perf_stall, PERF ? 32'd3 : 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("perf_fetch10", perf_fetched, PERF ? 32'd10 : 32'd0);
    check("perf_stall3b", perf_stall, PERF ? 32'd3 : 32'd0);

    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    check("br_pcsel", 32'(pcsel), 32'd2);
    check("br_dest", br_dest_o, 32'h100);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("br1_flush", 32'(flush), 32'd1);
    check("br1_valid", 32'(if_valid), 32'd0);
    check("br1_pcsel", 32'(pcsel), 32'd1);
    check("br1_dest", br_dest_o, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("br2_flush", 32'(flush), 32'd0);
    check("br2_valid", 32'(if_valid), 32'd0);
    check("br2_pcsel", 32'(pcsel), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("br3_valid", 32'(if_valid), 32'd1);

    cyc(1'b0, 1'b1, 32'h0000_0180, 1'b1, 1'b1);
    check("brst_pcsel", 32'(pcsel), 32'd2);
    check("brst_dest", br_dest_o, 32'h180);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("brst_flush", 32'(flush), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("brst_valid", 32'(if_valid), 32'd1);

    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("w0_pcsel", 32'(pcsel), 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    check("w1_pcsel", 32'(pcsel), 32'd0);
    check("w1_dest", br_dest_o, 32'd0);
    check("w1_flush", 32'(flush), 32'd0);
    cyc(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    check("w2_pcsel", 32'(pcsel), 32'd0);
    check("w2_flush", 32'(flush), 32'd1);
    check("w2_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("w3_pcsel", 32'(pcsel), 32'd0);
    check("w3_flush", 32'(flush), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("w4_pcsel", 32'(pcsel), 32'd2);
    check("w4_dest", br_dest_o, 32'h300);
    check("w4_flush", 32'(flush), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("w5_pcsel", 32'(pcsel), 32'd1);
    check("w5_flush", 32'(flush), 32'd0);
    check("w5_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("w7_valid", 32'(if_valid), 32'd1);

    cyc(1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    check("p0_pcsel", 32'(pcsel), 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("p1_pcsel", 32'(pcsel), 32'd0);
    check("p1_dest", br_dest_o, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("p2_pcsel", 32'(pcsel), 32'd0);
    check("p2_flush", 32'(flush), 32'd0);
    check("p2_pstall", perf_stall, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("p3_pcsel", 32'(pcsel), 32'd1);
    check("p3_dest", br_dest_o, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("p4_valid", 32'(if_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the in-order instruction fetch stage.
- Each cycle it chooses the fetch PC-select code: hold, sequential (PC+4) or redirect.
- It sources the redirect target and marks fetched instructions valid or as bubbles for decode.
- It arbitrates decode stalls, taken branches and instruction-memory wait states, and inserts a configurable number of bubbles after each redirect.

Parameters:
- XLEN, 32, PC/target width.
- REDIRECT_BUBBLES, 1, invalid fetch cycles after a redirect (range 0–3).
- PCSEL_HOLD, 2'b00, pcsel code: PC unchanged.
- PCSEL_PC4, 2'b01, pcsel code: PC+4.
- PCSEL_BRANCH, 2'b10, pcsel code: load from br_dest_o.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- br_taken  in  1  execute resolved a taken branch/jump this cycle.
- br_target  in  XLEN  target of the taken branch; valid only with br_taken.
- id_stall  in  1  decode cannot accept a new instruction.
- imem_rdy  in  1  instruction memory returns data this cycle (0 = wait state).
- pcsel  out  2  PC-select code to fetch; combinational.
- br_dest_o  out  XLEN  redirect address to fetch; combinational.
- if_valid  out  1  registered; the IF/ID instruction is real (0 = bubble).
- flush  out  1  registered one-cycle pulse; decode/execute squash wrong-path instructions.
- perf_fetched  out  32  count of valid instructions delivered (feature-gated).
- perf_stall  out  32  count of non-advancing cycles (feature-gated).

Behaviour:
- Reset values: state=BOOT, if_valid=0, flush=0, bubble counter=0, pending-redirect flag=0, perf counters=0.
- While reset is high, pcsel=HOLD and br_dest_o=0.
- FSM states:
  - BOOT: one cycle, pcsel=HOLD, then RUN.
  - RUN: normal fetch.
  - MEMWAIT: waiting on imem_rdy.
  - STALL: decode stalled.
  - BUBBLE: post-redirect drain.
- Priority within a cycle: reset > br_taken > !imem_rdy > id_stall > advance.
- br_taken in RUN, STALL or BUBBLE:
  - pcsel=BRANCH and br_dest_o=br_target in the same cycle.
  - flush=1 next cycle.
  - if_valid=0 next cycle.
  - Bubble counter loads REDIRECT_BUBBLES. If that is 0, go to RUN; otherwise go to BUBBLE.
- br_taken in MEMWAIT (or with imem_rdy=0):
  - Latch br_target into a pending register and set the pending flag.
  - pcsel=HOLD.
  - flush=1 next cycle; assert flush only once per branch.
  - On the first cycle with imem_rdy=1, issue pcsel=BRANCH with br_dest_o equal to the latched target, then clear pending.
  - A second br_taken while pending overwrites the latched target; the newest branch wins.
- imem_rdy=0 in any non-BOOT state: pcsel=HOLD, go to MEMWAIT, if_valid=0 next cycle.
- MEMWAIT → RUN (or STALL if id_stall) when imem_rdy=1.
- id_stall=1 with imem_rdy=1 and no branch: pcsel=HOLD, state STALL, if_valid holds its previous value.
- STALL → RUN when id_stall=0.
- BUBBLE:
  - pcsel=PC4 and if_valid=0; the counter decrements each cycle with imem_rdy=1.
  - Enter RUN when the counter reaches 1→0.
  - id_stall is ignored in BUBBLE (nothing valid is in decode).
- RUN with imem_rdy=1 and id_stall=0: pcsel=PC4, if_valid=1 next cycle.
- br_dest_o=0 whenever pcsel is not BRANCH.
- Reset asserted mid-MEMWAIT or mid-BUBBLE discards the pending target and the counter.

Optional Feature:
- FETCH_PERF_EN defined:
  - perf_fetched increments on every cycle whose registered if_valid=1 and id_stall=0.
  - perf_stall increments on every cycle where pcsel=HOLD after BOOT.
  - Both counters wrap modulo 2^32.
- FETCH_PERF_EN undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Reset and boot:
  - Stimulus: reset high 3 cycles, then release with imem_rdy=1, id_stall=0, br_taken=0.
  - Required response: pcsel=00 in the first cycle after release, then 01 every cycle; if_valid rises 2 cycles after release.
- Taken branch:
  - Stimulus: in RUN, br_taken=1 with br_target=0x0000_0100 for 1 cycle, REDIRECT_BUBBLES=1.
  - Required response: same cycle pcsel=10 and br_dest_o=0x100; next cycle flush=1, if_valid=0; one cycle later pcsel=01; if_valid=1 after that.
- Memory wait with branch:
  - Stimulus: imem_rdy=0 for 4 cycles, with br_taken (target 0x200) in wait-cycle 2 and br_taken (target 0x300) in wait-cycle 3.
  - Required response: pcsel=00 throughout the wait; a single flush pulse; when imem_rdy returns, pcsel=10 with br_dest_o=0x300.
- Decode stall:
  - Stimulus: id_stall=1 for 3 cycles in RUN.
  - Required response: pcsel=00 for 3 cycles and if_valid unchanged; then pcsel=01.
- Branch over stall:
  - Stimulus: id_stall=1 and br_taken=1 in the same cycle.
  - Required response: pcsel=10, flush=1 next cycle.
- FETCH_PERF_EN:
  - Stimulus: 10 advancing cycles with no stalls or branches, then 3 stalled cycles.
  - Required response: perf_fetched=10 (allowing for the if_valid pipeline latency), perf_stall=3 (plus any boot-hold cycle counted per the rule above).
